// File: rtl/count_monitor.sv
// Reader-side checker for a 4-bit enable/init up-counter: predicts each count from the
// previous sample, flags and counts mismatches, and reports enable-caused wraps.
module count_monitor #(
    parameter int NB_BITS     = 4,
    parameter int ERR_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               dut_resetb_i,
    input  logic               enable_i,
    input  logic               init_i,
    input  logic [NB_BITS-1:0] count_i,
    output logic [NB_BITS-1:0] expected_o,
    output logic               mismatch_o,
    output logic               fail_o,
    output logic [ERR_W-1:0]   err_count_o,
    output logic               wrap_o,
    output logic               synced_o
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_CHECK = 2'd1,
        ST_FAIL  = 2'd2
    } state_t;

    localparam logic [NB_BITS-1:0] CNT_MAX = {NB_BITS{1'b1}};
    localparam logic [ERR_W-1:0]   ERR_MAX = {ERR_W{1'b1}};

    // Counter reference model: reset > init > enable > hold, modular increment.
    function automatic logic [NB_BITS-1:0] f_model(
        input logic [NB_BITS-1:0] cur,
        input logic               rstb,
        input logic               init,
        input logic               en
    );
        logic [NB_BITS-1:0] nxt;
        if (!rstb) begin
            nxt = '0;
        end else if (init) begin
            nxt = '0;
        end else if (en) begin
            nxt = cur + NB_BITS'(1);
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    function automatic logic [ERR_W-1:0] f_sat_inc(input logic [ERR_W-1:0] v);
        logic [ERR_W-1:0] r;
        if (v == ERR_MAX) begin
            r = v;
        end else begin
            r = v + ERR_W'(1);
        end
        return r;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NB_BITS-1:0] r_prev_cnt;
    logic               r_prev_rstb;
    logic               r_prev_init;
    logic               r_prev_en;
    logic [NB_BITS-1:0] w_exp;
    logic               w_mis;
    logic               w_wrap;

    // State register.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, comparison and wrap detection; a same-edge counter reset forces exp to 0.
    always_comb begin
        w_state_nxt = r_state;
        w_mis       = 1'b0;
        w_wrap      = 1'b0;
        if (!dut_resetb_i) begin
            w_exp = '0;
        end else begin
            w_exp = f_model(r_prev_cnt, r_prev_rstb, r_prev_init, r_prev_en);
        end
        case (r_state)
            ST_SYNC: begin
                w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                w_mis = (count_i != w_exp);
                if (w_mis && STOP_ON_ERR) begin
                    w_state_nxt = ST_FAIL;
                end else begin
                    w_state_nxt = ST_CHECK;
                end
                w_wrap = !w_mis && dut_resetb_i && (r_prev_cnt == CNT_MAX) &&
                         (count_i == '0) && r_prev_en && !r_prev_init && r_prev_rstb;
            end
            ST_FAIL: begin
                w_state_nxt = ST_FAIL;
            end
            default: begin
                w_state_nxt = ST_SYNC;
            end
        endcase
    end

    // History always follows the observed count so a single corruption flags only once.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_prev_cnt  <= '0;
            r_prev_rstb <= 1'b0;
            r_prev_init <= 1'b0;
            r_prev_en   <= 1'b0;
        end else begin
            r_prev_cnt  <= count_i;
            r_prev_rstb <= dut_resetb_i;
            r_prev_init <= init_i;
            r_prev_en   <= enable_i;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            expected_o  <= '0;
            mismatch_o  <= 1'b0;
            fail_o      <= 1'b0;
            err_count_o <= '0;
            wrap_o      <= 1'b0;
            synced_o    <= 1'b0;
        end else begin
            expected_o <= f_model(count_i, dut_resetb_i, init_i, enable_i);
            mismatch_o <= w_mis;
            wrap_o     <= w_wrap;
            synced_o   <= (w_state_nxt != ST_SYNC);
            if (w_mis) begin
                fail_o      <= 1'b1;
                err_count_o <= f_sat_inc(err_count_o);
            end else begin
                fail_o      <= fail_o;
                err_count_o <= err_count_o;
            end
        end
    end

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: three instances (default, STOP_ON_ERR=1, ERR_W=2)
// share one stimulus stream; expected values are hand-computed per step.
module tb_count_monitor;

    logic       clk = 1'b0;
    logic       reset_i, dut_resetb_i, enable_i, init_i;
    logic [3:0] count_i;

    logic [3:0] exp0, exp1, exp2;
    logic       mis0, mis1, mis2, fail0, fail1, fail2, wrap0, wrap1, wrap2;
    logic       syn0, syn1, syn2;
    logic [7:0] err0, err1;
    logic [1:0] err2;

    int n_vec = 0;
    int n_err = 0;
    int mis0_n, wrap0_n, mis1_n, mis2_n;

    always #5 clk = ~clk;

    count_monitor u_dut0 (
        .clock_i(clk), .reset_i(reset_i), .dut_resetb_i(dut_resetb_i),
        .enable_i(enable_i), .init_i(init_i), .count_i(count_i),
        .expected_o(exp0), .mismatch_o(mis0), .fail_o(fail0),
        .err_count_o(err0), .wrap_o(wrap0), .synced_o(syn0));

    count_monitor #(.STOP_ON_ERR(1'b1)) u_dut1 (
        .clock_i(clk), .reset_i(reset_i), .dut_resetb_i(dut_resetb_i),
        .enable_i(enable_i), .init_i(init_i), .count_i(count_i),
        .expected_o(exp1), .mismatch_o(mis1), .fail_o(fail1),
        .err_count_o(err1), .wrap_o(wrap1), .synced_o(syn1));

    count_monitor #(.ERR_W(2)) u_dut2 (
        .clock_i(clk), .reset_i(reset_i), .dut_resetb_i(dut_resetb_i),
        .enable_i(enable_i), .init_i(init_i), .count_i(count_i),
        .expected_o(exp2), .mismatch_o(mis2), .fail_o(fail2),
        .err_count_o(err2), .wrap_o(wrap2), .synced_o(syn2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Apply one set of inputs, let an edge sample them, then look 1 time unit later.
    task automatic step(input logic rst, input logic rstb, input logic en,
                        input logic ini, input logic [3:0] cnt);
        reset_i      = rst;
        dut_resetb_i = rstb;
        enable_i     = en;
        init_i       = ini;
        count_i      = cnt;
        @(posedge clk);
        #1;
        mis0_n  += int'(mis0);
        wrap0_n += int'(wrap0);
        mis1_n  += int'(mis1);
        mis2_n  += int'(mis2);
    endtask

    initial begin
        mis0_n = 0; wrap0_n = 0; mis1_n = 0; mis2_n = 0;

        // Reset: two cycles, all outputs clear
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("rst_expected", 32'(exp0), 32'd0);
        chk("rst_mismatch", 32'(mis0), 32'd0);
        chk("rst_fail",     32'(fail0), 32'd0);
        chk("rst_err",      32'(err0), 32'd0);
        chk("rst_wrap",     32'(wrap0), 32'd0);
        chk("rst_synced",   32'(syn0), 32'd0);

        // Reset then count 0..15,0,1
        mis0_n = 0; wrap0_n = 0;
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        chk("sync_synced", 32'(syn0), 32'd1);
        chk("sync_expected", 32'(exp0), 32'd1);
        for (int k = 1; k < 16; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 4'(k));
            chk("count_expected", 32'(exp0), 32'((k + 1) % 16));
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        chk("wrap_pulse", 32'(wrap0), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd1);
        chk("wrap_one_cycle", 32'(wrap0), 32'd0);
        chk("count_wrap_total", 32'(wrap0_n), 32'd1);
        chk("count_mis_total",  32'(mis0_n), 32'd0);
        chk("count_err",        32'(err0), 32'd0);
        chk("count_fail",       32'(fail0), 32'd0);

        // Hold at 6 for three cycles, then init+enable at 9
        mis0_n = 0; wrap0_n = 0;
        for (int k = 2; k < 6; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'(k));
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd6);
        chk("hold_expected", 32'(exp0), 32'd6);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd6);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd6);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd6);
        chk("hold_release_expected", 32'(exp0), 32'd7);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd7);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd8);
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd9);
        chk("init_expected", 32'(exp0), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        chk("init_mismatch", 32'(mis0), 32'd0);
        chk("init_wrap",     32'(wrap0), 32'd0);
        chk("hold_init_mis_total", 32'(mis0_n), 32'd0);

        // Corruption: 3 where 7 is expected, then resync on 4,5,6
        for (int k = 1; k < 7; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'(k));
        chk("pre_corrupt_expected", 32'(exp0), 32'd7);
        mis0_n = 0; mis1_n = 0;
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd3);
        chk("corrupt_mismatch", 32'(mis0), 32'd1);
        chk("corrupt_err",      32'(err0), 32'd1);
        chk("corrupt_fail",     32'(fail0), 32'd1);
        chk("stop_mismatch",    32'(mis1), 32'd1);
        chk("stop_err",         32'(err1), 32'd1);
        for (int k = 4; k < 7; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 4'(k));
            chk("resync_mismatch", 32'(mis0), 32'd0);
        end
        chk("resync_mis_total", 32'(mis0_n), 32'd1);
        chk("resync_err",       32'(err0), 32'd1);
        chk("resync_fail",      32'(fail0), 32'd1);

        // STOP_ON_ERR instance stays frozen on further wrong values
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'hA);
        chk("free_mismatch_A", 32'(mis0), 32'd1);
        chk("frozen_mismatch_A", 32'(mis1), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'h2);
        chk("free_err_after_2", 32'(err0), 32'd3);
        chk("frozen_mis_total", 32'(mis1_n), 32'd1);
        chk("frozen_err",       32'(err1), 32'd1);
        chk("frozen_fail",      32'(fail1), 32'd1);
        chk("frozen_synced",    32'(syn1), 32'd1);
        chk("sat2_err_after_3", 32'(err2), 32'd3);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'h3);
        chk("fail_exit_synced", 32'(syn1), 32'd0);
        chk("fail_exit_fail",   32'(fail1), 32'd0);
        chk("fail_exit_err",    32'(err1), 32'd0);
        chk("fail_exit_mis",    32'(mis1), 32'd0);
        chk("fail_exit_exp",    32'(exp1), 32'd0);

        // Counter reset mid-count: honoured reset accepted, ignored reset flagged
        mis0_n = 0;
        for (int k = 0; k < 13; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'(k));
        chk("pre_dutrst_expected", 32'(exp0), 32'd13);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        chk("dutrst_mismatch", 32'(mis0), 32'd0);
        chk("dutrst_expected", 32'(exp0), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        chk("post_dutrst_mismatch", 32'(mis0), 32'd0);
        chk("post_dutrst_wrap",     32'(wrap0), 32'd0);
        for (int k = 1; k < 13; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'(k));
        chk("dutrst_clean_total", 32'(mis0_n), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd13);
        chk("ignored_rst_mismatch", 32'(mis0), 32'd1);
        chk("ignored_rst_err",      32'(err0), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        chk("ignored_rst_recover",  32'(mis0), 32'd0);

        // Saturation with ERR_W=2: five corruptions in a row
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("sat_rst_err", 32'(err2), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        mis2_n = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd5);
        chk("sat_err_1", 32'(err2), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd9);
        chk("sat_err_2", 32'(err2), 32'd2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        chk("sat_err_3", 32'(err2), 32'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        chk("sat_err_4", 32'(err2), 32'd3);
        chk("sat_mis_4", 32'(mis2), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
        chk("sat_err_5", 32'(err2), 32'd3);
        chk("sat_wide_err", 32'(err0), 32'd5);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
        chk("sat_clean_mis", 32'(mis2), 32'd0);
        chk("sat_pulse_total", 32'(mis2_n), 32'd5);
        chk("sat_hold_err", 32'(err2), 32'd3);
        chk("sat_fail", 32'(fail2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
